// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-period helper.
package uart_pkg;

  // State encodings, kept as localparams so a receiver can share them.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POP   = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    POP   = S_POP,
    LATCH = S_LATCH,
    START = S_START,
    DATA  = S_DATA,
    STOP  = S_STOP
  } uart_state_t;

  // Clock cycles per serial bit, truncating toward zero.
  function automatic int clks_per_bit(input int clock_hz, input int baud);
    return clock_hz / baud;
  endfunction

endpackage

// File: rtl/fifo.sv
// Synchronous FIFO with registered read data; data_out updates the cycle after a read.
module fifo #(
  parameter int FIFO_SIZE      = 4,
  parameter int ITEM_SIZE_BITS = 8
) (
  input  logic                      CLOCK_50,
  input  logic                      RST_N,
  input  logic                      write,
  input  logic                      read,
  input  logic [ITEM_SIZE_BITS-1:0] data_in,
  output logic [ITEM_SIZE_BITS-1:0] data_out,
  output logic                      empty,
  output logic                      full
);
  localparam int PTR_W = (FIFO_SIZE > 1) ? $clog2(FIFO_SIZE) : 1;
  localparam int CNT_W = $clog2(FIFO_SIZE + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_SIZE - 1);

  logic [ITEM_SIZE_BITS-1:0] mem [FIFO_SIZE];
  logic [ITEM_SIZE_BITS-1:0] data_out_reg;
  logic [PTR_W-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]          count_reg;
  logic                      do_write, do_read;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CNT_W'(FIFO_SIZE));
  assign do_write = write && !full;
  assign do_read  = read && !empty;
  assign data_out = data_out_reg;

  // Storage array: write port only, no reset so it maps onto block RAM.
  always_ff @(posedge CLOCK_50) begin
    if (do_write) mem[wr_ptr_reg] <= data_in;
  end

  // Registered read port.
  always_ff @(posedge CLOCK_50) begin
    if (!RST_N)       data_out_reg <= '0;
    else if (do_read) data_out_reg <= mem[rd_ptr_reg];
  end

  // Pointer and occupancy bookkeeping; pointers wrap at FIFO_SIZE.
  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_write) wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
      if (do_read)  rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
      case ({do_write, do_read})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, pulsing bit_end on the terminal count.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic CLOCK_50,
  input  logic RST_N,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_reg;

  assign bit_end = enable && (count_reg == LAST);

  // Count up while enabled, wrapping to zero at the end of each bit.
  always_ff @(posedge CLOCK_50) begin
    if (!RST_N || clear) count_reg <= '0;
    else if (enable)     count_reg <= bit_end ? '0 : count_reg + 1'b1;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-draining 8N1 transmitter: pops one item per frame and shifts it out LSB first.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCK_HZ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8
) (
  input  logic                 CLOCK_50,
  input  logic                 RST_N,
  input  logic [DATA_BITS-1:0] fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_read,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_HZ, BAUD);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_state_t          state_reg, state_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic                 tx_reg, tx_next;
  logic                 baud_clear, baud_enable, bit_end;

  // A bit period shorter than two clocks cannot be timed by the counter.
  always_ff @(posedge CLOCK_50) begin
    assert (CLKS_PER_BIT >= 2)
      else $error("fifo_uart_tx: CLKS_PER_BIT=%0d is below 2", CLKS_PER_BIT);
  end

  assign baud_clear  = (state_reg == LATCH);
  assign baud_enable = (state_reg == START) || (state_reg == DATA) || (state_reg == STOP);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .CLOCK_50 (CLOCK_50),
    .RST_N    (RST_N),
    .clear    (baud_clear),
    .enable   (baud_enable),
    .bit_end  (bit_end)
  );

  // Pop strobe and status are decoded from the state register alone.
  assign fifo_read  = (state_reg == POP);
  assign busy       = (state_reg != IDLE);
  assign frame_done = (state_reg == STOP) && bit_end;
  assign tx         = tx_reg;

  // State, shift register, bit index and line register.
  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      idx_reg   <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      idx_reg   <= idx_next;
      tx_reg    <= tx_next;
    end
  end

  // Next-state logic: IDLE -> POP -> LATCH -> START -> DATA x DATA_BITS -> STOP.
  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    idx_next   = idx_reg;
    unique case (state_reg)
      IDLE:  if (!fifo_empty) state_next = POP;
      POP:   state_next = LATCH;
      LATCH: begin
        shift_next = fifo_data;
        idx_next   = '0;
        state_next = START;
      end
      START: if (bit_end) state_next = DATA;
      DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          idx_next   = idx_reg + 1'b1;
          if (idx_reg == LAST_IDX) state_next = STOP;
        end
      end
      STOP:  if (bit_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Line value for the coming cycle, so tx comes straight from a flop.
  always_comb begin
    tx_next = 1'b1;
    if (state_next == START)     tx_next = 1'b0;
    else if (state_next == DATA) tx_next = shift_next[0];
  end

endmodule
